// File: rtl/vga_fifo_scanout.sv
// VGA scanout engine: timing generator, line-ahead load requests to the FIFO loader,
// and registered gray pixel/sync/blank outputs popped from a show-ahead line FIFO.
module vga_fifo_scanout #(
  parameter int H_ACTIVE         = 1280,
  parameter int H_FP             = 48,
  parameter int H_SYNC           = 112,
  parameter int H_BP             = 248,
  parameter int V_ACTIVE         = 1024,
  parameter int V_FP             = 1,
  parameter int V_SYNC           = 3,
  parameter int V_BP             = 38,
  parameter int REQ_H_POS        = 1280,
  parameter int REQ_PULSE_CYCLES = 4
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iENABLE,
  input  logic [7:0]  iFIFO_RDATA,
  input  logic        iFIFO_EMPTY,
  output logic        oFIFO_REN,
  output logic        oFIFO_CLR,
  output logic [12:0] oVGA_LINE_TO_LOAD,
  output logic        oVGA_LOAD_TO_FIFO_REQ,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oUNDERFLOW
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST_ACT = 11'(V_ACTIVE - 1);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] REQ_H      = 11'(REQ_H_POS);
  localparam logic [2:0]  REQ_LOAD   = 3'(REQ_PULSE_CYCLES);

  logic [10:0] hCnt;
  logic [10:0] vCnt;
  logic        enLatched;
  logic [2:0]  reqTimer;
  logic [7:0]  pixel;

  logic active;
  logic hSync;
  logic vSync;
  logic frameStart;
  logic vsyncStart;
  logic reqTrigger;
  logic underrun;

  always_comb begin
    active     = (hCnt < H_ACT) && (vCnt < V_ACT);
    hSync      = (hCnt >= H_SYNC_ON) && (hCnt < H_SYNC_OFF);
    vSync      = (vCnt >= V_SYNC_ON) && (vCnt < V_SYNC_OFF);
    frameStart = (hCnt == 11'd0) && (vCnt == 11'd0);
    vsyncStart = (hCnt == 11'd0) && (vCnt == V_SYNC_ON);
    // Request one line ahead; the last active line has no successor, the last
    // blanking line pre-loads line 0 of the next frame.
    reqTrigger = enLatched && (hCnt == REQ_H) && ((vCnt < V_LAST_ACT) || (vCnt == V_LAST));
    underrun   = active && enLatched && iFIFO_EMPTY;
    oFIFO_REN  = active && enLatched && !iFIFO_EMPTY;
  end

  // NOTE: every register below uses non-blocking assignments so all state
  // updates see the same pre-edge counter values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      hCnt      <= '0;
      vCnt      <= '0;
      enLatched <= 1'b0;
    end else begin
      if (hCnt == H_LAST) begin
        hCnt <= '0;
        vCnt <= (vCnt == V_LAST) ? 11'd0 : vCnt + 11'd1;
      end else begin
        hCnt <= hCnt + 11'd1;
      end
      if (frameStart) enLatched <= iENABLE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_HS      <= 1'b0;
      oVGA_VS      <= 1'b0;
      oVGA_BLANK_N <= 1'b0;
      pixel        <= '0;
      oFIFO_CLR    <= 1'b0;
      oUNDERFLOW   <= 1'b0;
    end else begin
      oVGA_HS      <= hSync;
      oVGA_VS      <= vSync;
      oVGA_BLANK_N <= active;
      pixel        <= oFIFO_REN ? iFIFO_RDATA : 8'd0;
      oFIFO_CLR    <= vsyncStart;
      if (vsyncStart)    oUNDERFLOW <= 1'b0;
      else if (underrun) oUNDERFLOW <= 1'b1;
    end
  end

  // The strobe is stretched so the loader's slower clock domain can sample it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      reqTimer          <= '0;
      oVGA_LINE_TO_LOAD <= '0;
    end else if (reqTrigger) begin
      reqTimer          <= REQ_LOAD;
      oVGA_LINE_TO_LOAD <= (vCnt == V_LAST) ? 13'd0 : 13'(vCnt) + 13'd1;
    end else if (reqTimer != 3'd0) begin
      reqTimer <= reqTimer - 3'd1;
    end
  end

  assign oVGA_LOAD_TO_FIFO_REQ = (reqTimer != 3'd0);
  assign oVGA_R = pixel;
  assign oVGA_G = pixel;
  assign oVGA_B = pixel;

endmodule
